// File: rtl/vga_pkg.sv
// Shared constants, pixel type and colour expansion for the VGA scanout path.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int FB_ADDR_W = 20;
    localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;

    typedef logic [8:0] pixel_t;

    // Replicating the 3-bit code keeps 000 -> 00 and 111 -> FF exactly.
    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Frame buffer read port as seen by the scanout (master) and the RAM (slave).
interface vga_scanout_if;

    logic                           re;
    logic [vga_pkg::FB_ADDR_W-1:0]  read_addr;
    vga_pkg::pixel_t                data_in;

    modport master (output re, output read_addr, input data_in);
    modport slave  (input re, input read_addr, output data_in);

endinterface

// File: rtl/vga_timing.sv
// Pixel divider and h/v raster counters; raw sync/active are undelayed.
// VGA_SCANOUT_TEST_PATTERN_EN adds the colour bar index output.
module vga_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic       vga_clk,
    output logic       frame_start,
    output logic       active,
    output logic       hsync_raw,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    output logic [2:0] bar_idx,
`endif
    output logic       vsync_raw
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    // Down-counter cleared by reset, so the first tick lands on the first clk after release.
    always_ff @(posedge clk) begin
        if (!rst_n)
            div <= '0;
        else if (div == '0)
            div <= DW'(CLK_DIV - 1);
        else
            div <= div - DW'(1);
    end

    assign pix_en  = (int'(div) == CLK_DIV - 1);
    assign vga_clk = (int'(div) >= CLK_DIV - CLK_DIV / 2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (int'(h_cnt) == H_TOTAL - 1) begin
                h_cnt <= '0;
                v_cnt <= (int'(v_cnt) == V_TOTAL - 1) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);
    assign active      = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    // Sync outputs are active-low
    assign hsync_raw   = !((int'(h_cnt) >= H_ACTIVE + H_FP) &&
                           (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC));
    assign vsync_raw   = !((int'(v_cnt) >= V_ACTIVE + V_FP) &&
                           (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC));

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    assign bar_idx = 3'(int'(h_cnt) / 80);
`endif

endmodule

// File: rtl/vga_scanout.sv
// Frame buffer scanout: address generation, read pipeline and RGB333 -> 8:8:8 output.
// VGA_SCANOUT_TEST_PATTERN_EN adds a test_pattern input selecting 8 vertical colour bars.
module vga_scanout #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fb_initialized,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic              test_pattern,
`endif
    vga_scanout_if.master     fb,
    output logic              vga_clk,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank_n,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start
);

    import vga_pkg::*;

    logic pix_en, active, hsync_raw, vsync_raw, read_en;
    logic [FB_ADDR_W-1:0] addr_cnt, addr_now;
    logic   s1_active, s1_hsync, s1_vsync, s1_read;
    logic   s2_active, s2_hsync, s2_vsync;
    pixel_t s2_pix, pix_data, colour_src;
    logic   re_d;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    logic       s1_tp;
    pixel_t     s1_bar;
`endif

    vga_timing #(
        .CLK_DIV(CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .vga_clk     (vga_clk),
        .frame_start (frame_start),
        .active      (active),
        .hsync_raw   (hsync_raw),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        .bar_idx     (bar_idx),
`endif
        .vsync_raw   (vsync_raw)
    );

    always_comb begin
        addr_now = frame_start ? '0 : addr_cnt;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        read_en  = active && fb_initialized && !test_pattern;
`else
        read_en  = active && fb_initialized;
`endif
    end

    // Stage 1: issue the read; re is a single-clk strobe per active pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb.re        <= 1'b0;
            fb.read_addr <= '0;
            addr_cnt     <= '0;
            s1_active    <= 1'b0;
            s1_hsync     <= 1'b1;
            s1_vsync     <= 1'b1;
            s1_read      <= 1'b0;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
            s1_tp        <= 1'b0;
            s1_bar       <= '0;
`endif
        end else begin
            fb.re <= 1'b0;
            if (pix_en) begin
                fb.re        <= read_en;
                fb.read_addr <= addr_now;
                addr_cnt     <= active ? addr_now + FB_ADDR_W'(1) : addr_now;
                s1_active    <= active;
                s1_hsync     <= hsync_raw;
                s1_vsync     <= vsync_raw;
                s1_read      <= read_en;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
                s1_tp        <= test_pattern;
                s1_bar       <= {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {3{bar_idx[0]}}};
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            re_d     <= 1'b0;
            pix_data <= '0;
        end else begin
            re_d <= fb.re;
            if (re_d)
                pix_data <= fb.data_in;
        end
    end

    // At CLK_DIV=2 the read data arrives on the very clk of the next tick, hence the bypass.
    assign colour_src = re_d ? fb.data_in : pix_data;

    // Stage 2: pick the pixel colour and carry sync/blank along with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_active <= 1'b0;
            s2_hsync  <= 1'b1;
            s2_vsync  <= 1'b1;
            s2_pix    <= '0;
        end else if (pix_en) begin
            s2_active <= s1_active;
            s2_hsync  <= s1_hsync;
            s2_vsync  <= s1_vsync;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
            if (s1_tp)
                s2_pix <= s1_active ? s1_bar : '0;
            else
                s2_pix <= s1_read ? colour_src : '0;
`else
            s2_pix    <= s1_read ? colour_src : '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_blank_n <= 1'b0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else if (pix_en) begin
            vga_blank_n <= s2_active;
            vga_hsync   <= s2_hsync;
            vga_vsync   <= s2_vsync;
            vga_r       <= expand3(s2_pix[8:6]);
            vga_g       <= expand3(s2_pix[5:3]);
            vga_b       <= expand3(s2_pix[2:0]);
        end
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display-side consumer of the 640x480 frame buffer: generates 640x480@60 VGA timing and drives the buffer's read port (re, read_addr).
- Converts returned 9-bit RGB333 pixels to 8-bit-per-channel DAC outputs, with sync and blank aligned to the pixel data.
- Sits directly downstream of the dual-port frame buffer; drawing logic writes the buffer's other port.

Parameters:
- CLK_DIV, 2, clk cycles per pixel tick (50 MHz clk -> 25 MHz pixel rate); must be >= 2
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock; also the frame buffer clock
- rst_n  in  1  synchronous reset, active-low
- fb_initialized  in  1  frame buffer clear finished; when low, active video is forced black
- re  out  1  frame buffer read enable
- read_addr  out  20  frame buffer read address, linear row-major: y*640+x
- data_in  in  9  frame buffer read data, {R[8:6],G[5:3],B[2:0]}; valid 1 clk after re
- vga_clk  out  1  pixel clock: high for the first half of each pixel tick period
- vga_hsync  out  1  horizontal sync, active-low
- vga_vsync  out  1  vertical sync, active-low
- vga_blank_n  out  1  high during visible pixels
- vga_r, vga_g, vga_b  out  8 each  colour channels
- frame_start  out  1  one-clk pulse when h_cnt=0 and v_cnt=0 on a pixel tick

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - re=0, read_addr=0, vga_blank_n=0, RGB=0, frame_start=0.
  - vga_hsync=1, vga_vsync=1.
  - Counters and the divider are cleared.
  - Reset mid-frame restarts timing at h=0, v=0 on the first tick after release.
- Pixel tick:
  - pix_en pulses for one clk every CLK_DIV clks, starting on the first clk after reset release.
  - All timing state advances only on pix_en.
- Counters:
  - h_cnt runs 0..799 (H_TOTAL = sum of the H_* parameters) and wraps to 0.
  - v_cnt increments on each h wrap, runs 0..524 and wraps to 0.
  - Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Sync windows:
  - hsync is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync is asserted for lines 490..491 by the same rule.
- Pipeline stage 1 (pix_en):
  - re <= active && fb_initialized.
  - read_addr <= a linear address counter; the counter increments after each active pixel and returns to 0 at frame start. Max value 307199.
  - No multiplier is used.
- Pipeline stage 2:
  - data_in is sampled on the clk after re and held.
  - On the next pix_en, RGB, blank_n, hsync and vsync are registered together.
  - Total pipeline: counter value to output pins = 2 pixel ticks. Sync and blank are delayed by the same 2 ticks, so the pin outputs stay aligned.
- Colour expansion: each 3-bit channel c maps to 8 bits as {c,c,c[2:1]}.
  - 3'b111 -> 8'hFF; 3'b000 -> 8'h00.
- Outside the active region, or when fb_initialized=0: RGB=0 and re=0. Timing continues unaffected.
- fb_initialized changing mid-frame takes effect on the next pixel tick. No resynchronisation is performed.
- re is held for 1 clk per active pixel; read_addr holds its value between ticks.

Optional Feature:
- Macro: VGA_SCANOUT_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_pattern (1 bit).
  - When test_pattern=1, re is held at 0 and active pixels show 8 vertical colour bars, 80 px each, bar index = h_cnt/80. The 9-bit colour for bar i is {i[2],i[2],i[2],i[1],i[1],i[1],i[0],i[0],i[0]}. The colour passes through the same 2-tick pipeline.
- Undefined: the port is absent and the block reads only from the frame buffer.

Decomposition:
- Shared package vga_pkg:
  - H_/V_ timing constants, H_TOTAL=800, V_TOTAL=525.
  - FB_ADDR_W=20, FB_PIXELS=307200.
  - pixel_t typedef (9-bit RGB333).
  - The 3->8 channel expansion function.
- Sub-module vga_timing: divider, h/v counters, raw hsync/vsync/active, frame_start.
- vga_scanout keeps the address counter, read pipeline and colour output.

Test Plan:
- Reset held for 5 clks, then released -> all outputs at reset values. First frame_start occurs 1 clk after release, on the first pix_en.
- Run 2 full frames -> per line, hsync is low for exactly 96 ticks starting at h=656. Per frame, vsync is low for exactly 2 lines (490-491). Period is 800x525 ticks = 840000 clks at CLK_DIV=2.
- Read addresses:
  - Pixel (0,0) -> read_addr=0.
  - Pixel (639,0) -> 639.
  - Pixel (0,1) -> 640.
  - Pixel (639,479) -> 307199.
  - Next frame starts again at 0.
  - re is never asserted outside the active region.
- Data path: RAM model returns data_in=9'b111_000_101 for addr 641 -> the pin outputs show R=FF, G=00, B=B6 with blank_n=1, exactly 2 ticks after the counters reach (1,1).
- fb_initialized=0 for the whole frame -> re is never asserted, RGB stays 0, and sync timing is unchanged.
- With VGA_SCANOUT_TEST_PATTERN_EN defined and test_pattern=1 -> pixel x=85 shows the bar-1 colour (R=00, G=00, B=FF), x=639 shows white (FF,FF,FF), and re stays 0.
